// File: rtl/dda_pkg.sv
// Shared types for the multi-axis DDA: default widths and the signed-magnitude velocity word.
package dda_pkg;

  localparam int DDA_VW    = 8;
  localparam int DDA_ACC_W = 16;

  typedef struct packed {
    logic              neg;
    logic [DDA_VW-2:0] mag;
  } vel_t;

  function automatic logic [DDA_VW-2:0] vel_mag(input vel_t v);
    return v.mag;
  endfunction

endpackage

// File: rtl/dda_seg_fifo.sv
// Segment command FIFO: DEPTH entries of W bits, synchronous clear, occupancy count.
module dda_seg_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] cnt,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;

  // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: storage is not reset; the count alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign cnt   = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/dda_multi_axis_interp.sv
// Multi-axis DDA step/dir generator: queued velocity segments, one phase accumulator per axis.
module dda_multi_axis_interp
  import dda_pkg::*;
#(
  parameter int AXES      = 2,
  parameter int VW        = DDA_VW,
  parameter int ACC_W     = DDA_ACC_W,
  parameter int DEPTH     = 4,
  parameter int TICK_DIV  = 100,
  parameter int SEG_TICKS = 10,
  parameter int ACC_INIT  = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [AXES*VW-1:0]     cmd_data,
  input  logic [ACC_W-1:0]       n_div,
  output logic [AXES-1:0]        step,
  output logic [AXES-1:0]        dir,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   fifo_full,
  output logic                   busy,
  output logic                   seg_strobe,
  output logic                   underrun,
  output logic                   overspeed
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SEG_TICKS + 1);
  localparam int HW = $clog2(TICK_DIV / 2);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]        seg_cnt_q, seg_cnt_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 first_q, first_d;
  logic [AXES*VW-1:0]   active_q, active_d, vel_use, fifo_head;
  logic [AXES-1:0]      dir_q, dir_d, step_q, step_d, fire, fast, neg;
  logic [ACC_W-1:0]     acc_q [AXES];
  logic [ACC_W-1:0]     acc_d [AXES];
  logic [ACC_W-1:0]     acc_nx [AXES];
  logic                 seg_strobe_q, seg_strobe_d, underrun_q, underrun_d;
  logic                 overspeed_q, overspeed_d;
  logic                 tick, boundary, push, pop, fifo_empty;

  dda_seg_fifo #(.W(AXES*VW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (cmd_data),
    .dout  (fifo_head),
    .cnt   (fifo_cnt),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // The boundary tick already plays the freshly popped velocity (or zero on an empty FIFO).
  always_comb begin
    tick     = (tick_cnt_q == TW'(TICK_DIV - 1));
    boundary = tick && (first_q || seg_cnt_q == SW'(SEG_TICKS - 1));
    pop      = boundary && !fifo_empty && !clear;
    push     = cmd_valid && cmd_ready && !clear;
    vel_use  = active_q;
    if (boundary) vel_use = fifo_empty ? '0 : fifo_head;
  end

  for (genvar k = 0; k < AXES; k++) begin : g_axis
    vel_t         vel;
    logic [ACC_W:0] mag, sum, rem;
    assign vel       = vel_t'(vel_use[k*VW +: VW]);
    assign neg[k]    = vel.neg;
    assign mag       = (ACC_W+1)'(vel_mag(vel));
    assign sum       = {1'b0, acc_q[k]} + mag;
    assign rem       = sum - {1'b0, n_div};
    assign fire[k]   = (n_div != '0) && (sum >= {1'b0, n_div});
    assign fast[k]   = (n_div != '0) && (mag >= {1'b0, n_div});
    assign acc_nx[k] = (n_div == '0) ? acc_q[k] :
                       !fire[k]      ? sum[ACC_W-1:0] :
                       rem[ACC_W]    ? ACC_MAX : rem[ACC_W-1:0];
  end

  always_comb begin
    tick_cnt_d   = tick_cnt_q;
    seg_cnt_d    = seg_cnt_q;
    hold_d       = hold_q;
    first_d      = first_q;
    active_d     = active_q;
    dir_d        = dir_q;
    step_d       = step_q;
    acc_d        = acc_q;
    overspeed_d  = overspeed_q;
    seg_strobe_d = 1'b0;
    underrun_d   = 1'b0;
    if (clear) begin
      tick_cnt_d  = '0;
      seg_cnt_d   = '0;
      hold_d      = '0;
      first_d     = 1'b1;
      active_d    = '0;
      step_d      = '0;
      overspeed_d = 1'b0;
      for (int k = 0; k < AXES; k++) acc_d[k] = ACC_W'(ACC_INIT);
    end else begin
      tick_cnt_d   = tick ? '0 : tick_cnt_q + TW'(1);
      seg_strobe_d = boundary;
      underrun_d   = boundary && fifo_empty && busy;
      if (tick) begin
        first_d     = 1'b0;
        seg_cnt_d   = boundary ? '0 : seg_cnt_q + SW'(1);
        active_d    = vel_use;
        step_d      = fire;
        hold_d      = HW'(TICK_DIV / 2 - 1);
        overspeed_d = overspeed_q | (|fast);
        if (boundary && !fifo_empty) dir_d = neg;
        for (int k = 0; k < AXES; k++) acc_d[k] = acc_nx[k];
      end else if (hold_q != '0) begin
        hold_d = hold_q - HW'(1);
      end else begin
        step_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q   <= '0;
      seg_cnt_q    <= '0;
      hold_q       <= '0;
      first_q      <= 1'b1;
      active_q     <= '0;
      dir_q        <= '0;
      step_q       <= '0;
      acc_q        <= '{default: ACC_W'(ACC_INIT)};
      seg_strobe_q <= 1'b0;
      underrun_q   <= 1'b0;
      overspeed_q  <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      seg_cnt_q    <= seg_cnt_d;
      hold_q       <= hold_d;
      first_q      <= first_d;
      active_q     <= active_d;
      dir_q        <= dir_d;
      step_q       <= step_d;
      acc_q        <= acc_d;
      seg_strobe_q <= seg_strobe_d;
      underrun_q   <= underrun_d;
      overspeed_q  <= overspeed_d;
    end
  end

  assign cmd_ready  = !fifo_full;
  assign busy       = (active_q != '0) || (fifo_cnt != '0);
  assign step       = step_q;
  assign dir        = dir_q;
  assign seg_strobe = seg_strobe_q;
  assign underrun   = underrun_q;
  assign overspeed  = overspeed_q;

endmodule

// File: tb/tb_dda_multi_axis_interp.sv
// Bench for dda_multi_axis_interp: tick-level behavioural model checked every cycle, plus directed literals.
module tb_dda_multi_axis_interp;
  localparam int AX = 2, VWB = 8, ACCW = 16, DEP = 4, TD = 100, ST = 10, AI = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [AX*VWB-1:0] cmd_data = '0;
  logic [ACCW-1:0]  n_div = 16'd100;
  logic [AX-1:0]    step, dir;
  logic [2:0]       fifo_cnt;
  logic             fifo_full, busy, seg_strobe, underrun, overspeed;

  int checks = 0;
  int errors = 0;

  dda_multi_axis_interp #(
    .AXES(AX), .VW(VWB), .ACC_W(ACCW), .DEPTH(DEP),
    .TICK_DIV(TD), .SEG_TICKS(ST), .ACC_INIT(AI)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .n_div      (n_div),
    .step       (step),
    .dir        (dir),
    .fifo_cnt   (fifo_cnt),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .seg_strobe (seg_strobe),
    .underrun   (underrun),
    .overspeed  (overspeed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: ticks every TD cycles, segments every ST ticks
  logic [15:0] mq[$];
  int          m_phase, m_ticks, m_since;
  int          m_acc [AX];
  logic [15:0] m_active;
  logic [1:0]  m_dir, m_fire;
  bit          m_strobe, m_under, m_ovs;

  task automatic m_init(input bit full_reset);
    mq.delete();
    m_phase = 0; m_ticks = 0; m_since = TD;
    m_active = '0; m_fire = '0;
    m_strobe = 0; m_under = 0; m_ovs = 0;
    for (int k = 0; k < AX; k++) m_acc[k] = AI;
    if (full_reset) m_dir = '0;
  endtask

  task automatic m_cycle();
    int sz, nd, mag, sum;
    bit t, bnd, was_busy;
    logic [15:0] head;
    sz       = mq.size();
    t        = (m_phase == TD - 1);
    bnd      = t && (m_ticks % ST == 0);
    was_busy = (m_active != 0) || (sz != 0);
    head     = '0;
    if (sz != 0) head = mq[0];
    m_strobe = bnd;
    m_under  = bnd && (sz == 0) && was_busy;
    if (bnd && sz != 0) void'(mq.pop_front());
    if (cmd_valid && sz < DEP) mq.push_back(cmd_data);
    if (t) begin
      if (bnd) begin
        m_active = head;
        if (sz != 0) for (int k = 0; k < AX; k++) m_dir[k] = head[k*VWB + VWB - 1];
      end
      nd = int'(n_div);
      for (int k = 0; k < AX; k++) begin
        mag = int'(m_active[k*VWB +: VWB-1]);
        sum = m_acc[k] + mag;
        m_fire[k] = 1'b0;
        if (nd != 0 && mag >= nd) m_ovs = 1;
        if (nd != 0 && sum >= nd) begin
          m_fire[k] = 1'b1;
          m_acc[k]  = (sum - nd > 65535) ? 65535 : sum - nd;
        end else if (nd != 0) begin
          m_acc[k] = sum;
        end
      end
      m_ticks++;
      m_phase = 0;
      m_since = 0;
    end else begin
      m_phase++;
      if (m_since < TD) m_since++;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     m_init(1'b1);
    else if (clear) m_init(1'b0);
    else            m_cycle();
  end

  logic [1:0] e_step;
  always @(negedge clk) begin
    if (rst_n) begin
      e_step = (m_since < TD / 2) ? m_fire : 2'b00;
      check("step",       step,       e_step);
      check("dir",        dir,        m_dir);
      check("fifo_cnt",   fifo_cnt,   mq.size());
      check("fifo_full",  fifo_full,  mq.size() == DEP);
      check("cmd_ready",  cmd_ready,  mq.size() != DEP);
      check("busy",       busy,       (m_active != 0) || (mq.size() != 0));
      check("seg_strobe", seg_strobe, m_strobe);
      check("underrun",   underrun,   m_under);
      check("overspeed",  overspeed,  m_ovs);
    end
  end

  // ---------------- directed stimulus
  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] d);
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_strobe(input int budget, output int n);
    n = 0;
    do begin
      @(posedge clk); @(negedge clk);
      n++;
    end while (!seg_strobe && n < budget);
    check("strobe_seen", seg_strobe, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] burst [5];
  logic [10:1] pat;
  int n, nstrobe, nsteps;

  initial begin
    burst = '{16'h0505, 16'h0a0a, 16'h0f0f, 16'h1414, 16'h8585};
    skip(3);
    rst_n = 1'b1;
    check("rst_fifo_cnt",  fifo_cnt,  0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_step",      step,      0);
    check("rst_busy",      busy,      0);
    check("rst_overspeed", overspeed, 0);

    // +20 on axis 0 at n_div=100: acc 10 -> steps on ticks 5 and 10 of the segment
    push(16'h0014);
    wait_strobe(200, n);
    check("first_boundary_cycle", n + 1, 100);
    check("seg1_dir0", dir[0], 0);
    for (int i = 1; i <= 10; i++) begin
      pat[i] = step[0];
      skip(100);
    end
    check("seg1_step_pattern", pat, 10'b10_0001_0000);
    check("seg1_step_count", $countones(pat), 2);

    // FIFO empty at the next boundary
    check("underrun_pulse", underrun, 1);
    check("underrun_busy",  busy,     0);
    skip(1);
    check("underrun_one_cycle", underrun, 0);
    skip(99);
    check("idle_no_step", step, 0);

    // -20 on axis 1: dir rises at the boundary, first step 4 ticks later
    push(16'h9400);
    wait_strobe(1100, n);
    check("neg_dir1", dir[1], 1);
    n = 0;
    while (!step[1] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("dir_setup_min", n >= TD / 2, 1);
    check("dir_setup_cycles", n, 400);

    // five back-to-back pushes: only four fit
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmd_data = burst[i];
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("burst_cnt",   fifo_cnt,  4);
    check("burst_full",  fifo_full, 1);
    check("burst_ready", cmd_ready, 0);
    nstrobe = 0;
    n = 0;
    do begin
      @(posedge clk); @(negedge clk);
      n++;
      if (seg_strobe) nstrobe++;
    end while (!underrun && n < 6000);
    check("burst_underrun_seen", underrun, 1);
    check("burst_segments", nstrobe, 5);
    check("burst_dir_final", dir, 2'b00);

    // push landing exactly on a boundary with an empty FIFO: no bypass
    repeat (999) @(posedge clk);
    @(negedge clk);
    cmd_data  = 16'h8078;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("nobypass_strobe",   seg_strobe, 1);
    check("nobypass_cnt",      fifo_cnt,   1);
    check("nobypass_underrun", underrun,   0);

    // magnitude 120 > n_div: sticky overspeed, a step on every tick
    wait_strobe(1100, n);
    check("ovs_set", overspeed, 1);
    check("ovs_dir", dir, 2'b10);
    nsteps = 0;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) skip(100);
      nsteps += int'(step[0]);
    end
    check("ovs_steps_every_tick", nsteps, 5);
    check("ovs_sticky", overspeed, 1);

    // clear mid-pulse
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_step",      step,      0);
    check("clr_cnt",       fifo_cnt,  0);
    check("clr_overspeed", overspeed, 0);
    check("clr_busy",      busy,      0);
    check("clr_dir_hold",  dir,       2'b10);

    // acc restarts at 10 and the first tick after clear is a boundary
    push(16'h0014);
    wait_strobe(200, n);
    check("clr_first_boundary_cycle", n + 1, 100);
    skip(300);
    check("clr_tick4_no_step", step[0], 0);
    push(16'h0101);
    skip(99);
    check("clr_tick5_step", step[0], 1);
    check("pre_rst_cnt", fifo_cnt, 1);

    // async reset during a step pulse
    #1 rst_n = 1'b0;
    #1;
    check("arst_step",      step,      0);
    check("arst_cnt",       fifo_cnt,  0);
    check("arst_cmd_ready", cmd_ready, 1);
    check("arst_dir",       dir,       0);
    skip(3);
    rst_n = 1'b1;
    wait_strobe(200, n);
    check("rst_first_boundary_cycle", n, 100);
    check("rst_boundary_no_underrun", underrun, 0);

    skip(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
